// File: rtl/reg_file_n.sv
// reg_file_n: DEPTH x WIDTH register file with two combinational read ports,
// one synchronous write port, optional write-to-read bypass, optional
// hardwired-zero register 0, and a sequenced bulk-clear engine.
module reg_file_n #(
    parameter int WIDTH   = 4,
    parameter int DEPTH   = 4,
    parameter int AW      = $clog2(DEPTH),
    parameter int BYPASS  = 1,
    parameter int ZERO_R0 = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             WE,
    input  logic [AW-1:0]    SEL_W,
    input  logic [WIDTH-1:0] IN_W,
    input  logic [AW-1:0]    SEL_A,
    input  logic [AW-1:0]    SEL_B,
    output logic [WIDTH-1:0] OUT_A,
    output logic [WIDTH-1:0] OUT_B,
    input  logic             CLR,
    output logic             BUSY
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
    localparam logic [AW-1:0] ONE_IDX  = AW'(1);
    localparam logic [AW-1:0] ZERO_IDX = {AW{1'b0}};

    state_t           state_q;
    logic [AW-1:0]    ptr_q;
    logic             busy_q;
    logic [WIDTH-1:0] regs_q [DEPTH];

    logic             wr_en_d;
    logic [AW-1:0]    wr_idx_d;
    logic [WIDTH-1:0] wr_data_d;
    logic             byp_ok_s;
    logic             w_is_r0_s;

    // Decode which register (if any) is written at the next edge: the clear
    // engine owns the port in CLEAR, CLR beats WE in IDLE, r0 may be read-only.
    always_comb begin
        wr_en_d   = 1'b0;
        wr_idx_d  = ZERO_IDX;
        wr_data_d = {WIDTH{1'b0}};
        w_is_r0_s = (ZERO_R0 != 0) && (SEL_W == ZERO_IDX);
        case (state_q)
            ST_IDLE: begin
                if (!CLR && WE && !w_is_r0_s) begin
                    wr_en_d   = 1'b1;
                    wr_idx_d  = SEL_W;
                    wr_data_d = IN_W;
                end else begin
                    wr_en_d = 1'b0;
                end
            end
            ST_CLEAR: begin
                wr_en_d   = 1'b1;
                wr_idx_d  = ptr_q;
                wr_data_d = {WIDTH{1'b0}};
            end
            default: begin
                wr_en_d = 1'b0;
            end
        endcase
    end

    // Forwarding is only legal for a write that will actually land this edge;
    // it is masked while reset is held so the ports read 0 during reset.
    always_comb begin
        if ((BYPASS != 0) && !rst && (state_q == ST_IDLE) && wr_en_d) begin
            byp_ok_s = 1'b1;
        end else begin
            byp_ok_s = 1'b0;
        end
    end

    // Read ports: hardwired zero first, then same-cycle forwarding, then array.
    always_comb begin
        if ((ZERO_R0 != 0) && (SEL_A == ZERO_IDX)) begin
            OUT_A = {WIDTH{1'b0}};
        end else if (byp_ok_s && (SEL_A == SEL_W)) begin
            OUT_A = IN_W;
        end else begin
            OUT_A = regs_q[SEL_A];
        end
        if ((ZERO_R0 != 0) && (SEL_B == ZERO_IDX)) begin
            OUT_B = {WIDTH{1'b0}};
        end else if (byp_ok_s && (SEL_B == SEL_W)) begin
            OUT_B = IN_W;
        end else begin
            OUT_B = regs_q[SEL_B];
        end
    end

    // Clear sequencer: IDLE -> CLEAR on CLR, walk ptr up to DEPTH-1, then back.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= ZERO_IDX;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (CLR) begin
                        state_q <= ST_CLEAR;
                        ptr_q   <= ZERO_IDX;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= ST_IDLE;
                        ptr_q   <= ZERO_IDX;
                        busy_q  <= 1'b0;
                    end
                end
                ST_CLEAR: begin
                    if (ptr_q == LAST_IDX) begin
                        state_q <= ST_IDLE;
                        ptr_q   <= ZERO_IDX;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= ST_CLEAR;
                        ptr_q   <= ptr_q + ONE_IDX;
                        busy_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    ptr_q   <= ZERO_IDX;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Register array: cleared by reset, otherwise takes the decoded write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= {WIDTH{1'b0}};
            end
        end else begin
            if (wr_en_d) begin
                regs_q[wr_idx_d] <= wr_data_d;
            end
        end
    end

    assign BUSY = busy_q;

endmodule

// File: tb/tb_reg_file_n.sv
// Scoreboard bench for reg_file_n: four instances (default, no-bypass,
// 8x8, zero-r0). Stimulus pushes expected port values; a negedge monitor
// pops and compares them against the live outputs.
module tb_reg_file_n;

    typedef struct {
        int         dut;
        string      name;
        logic [7:0] a;
        logic [7:0] b;
        logic       busy;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    // shared 4x4 stimulus for duts 0 (default), 1 (no bypass), 3 (zero r0)
    logic       we4 = 1'b0, clr4 = 1'b0;
    logic [1:0] selw4 = 2'd0, sela4 = 2'd0, selb4 = 2'd0;
    logic [3:0] inw4 = 4'h0;
    logic [3:0] a0, b0, a1, b1, a3, b3;
    logic       bz0, bz1, bz3;

    // 8x8 stimulus for dut 2
    logic       we8 = 1'b0, clr8 = 1'b0;
    logic [2:0] selw8 = 3'd0, sela8 = 3'd0, selb8 = 3'd0;
    logic [7:0] inw8 = 8'h00;
    logic [7:0] a2, b2;
    logic       bz2;

    always #5 clk = ~clk;

    reg_file_n u_d0 (.clk(clk), .rst(rst), .WE(we4), .SEL_W(selw4), .IN_W(inw4),
                     .SEL_A(sela4), .SEL_B(selb4), .OUT_A(a0), .OUT_B(b0),
                     .CLR(clr4), .BUSY(bz0));
    reg_file_n #(.BYPASS(0)) u_d1 (.clk(clk), .rst(rst), .WE(we4), .SEL_W(selw4),
                     .IN_W(inw4), .SEL_A(sela4), .SEL_B(selb4), .OUT_A(a1),
                     .OUT_B(b1), .CLR(clr4), .BUSY(bz1));
    reg_file_n #(.WIDTH(8), .DEPTH(8)) u_d2 (.clk(clk), .rst(rst), .WE(we8),
                     .SEL_W(selw8), .IN_W(inw8), .SEL_A(sela8), .SEL_B(selb8),
                     .OUT_A(a2), .OUT_B(b2), .CLR(clr8), .BUSY(bz2));
    reg_file_n #(.ZERO_R0(1)) u_d3 (.clk(clk), .rst(rst), .WE(we4), .SEL_W(selw4),
                     .IN_W(inw4), .SEL_A(sela4), .SEL_B(selb4), .OUT_A(a3),
                     .OUT_B(b3), .CLR(clr4), .BUSY(bz3));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int dut, input string name, input logic [7:0] a,
                        input logic [7:0] b, input logic busy);
        exp_t e;
        e.dut = dut; e.name = name; e.a = a; e.b = b; e.busy = busy;
        sb_q.push_back(e);
    endtask

    // Monitor: compare every pending expectation against the outputs mid-cycle.
    always @(negedge clk) begin
        while (sb_q.size() != 0) begin
            exp_t       e;
            logic [7:0] ga, gb;
            logic       gbz;
            e = sb_q.pop_front();
            case (e.dut)
                0:       begin ga = {4'h0, a0}; gb = {4'h0, b0}; gbz = bz0; end
                1:       begin ga = {4'h0, a1}; gb = {4'h0, b1}; gbz = bz1; end
                2:       begin ga = a2;         gb = b2;         gbz = bz2; end
                default: begin ga = {4'h0, a3}; gb = {4'h0, b3}; gbz = bz3; end
            endcase
            checks++;
            if (ga !== e.a || gb !== e.b || gbz !== e.busy) begin
                errors++;
                $display("FAIL %s dut%0d: got a=%h b=%h busy=%b, want a=%h b=%h busy=%b",
                         e.name, e.dut, ga, gb, gbz, e.a, e.b, e.busy);
            end
        end
    end

    initial begin
        logic [3:0] wv [4];
        logic [1:0] pa [4];
        logic [1:0] pb [4];
        wv[0] = 4'hA; wv[1] = 4'h5; wv[2] = 4'hC; wv[3] = 4'h3;
        pa[0] = 2'd0; pa[1] = 2'd1; pa[2] = 2'd2; pa[3] = 2'd3;
        pb[0] = 2'd3; pb[1] = 2'd2; pb[2] = 2'd1; pb[3] = 2'd0;

        // reset state
        tick();
        for (int d = 0; d < 4; d++) push(d, "reset", 8'h00, 8'h00, 1'b0);
        tick();
        rst = 1'b0;

        // basic writes and dual reads
        for (int i = 0; i < 4; i++) begin
            we4 = 1'b1; selw4 = 2'(i); inw4 = wv[i];
            tick();
        end
        we4 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sela4 = pa[i]; selb4 = pb[i];
            push(0, "rd", {4'h0, wv[pa[i]]}, {4'h0, wv[pb[i]]}, 1'b0);
            push(1, "rd", {4'h0, wv[pa[i]]}, {4'h0, wv[pb[i]]}, 1'b0);
            push(3, "rd_z", (pa[i] == 2'd0) ? 8'h00 : {4'h0, wv[pa[i]]},
                 (pb[i] == 2'd0) ? 8'h00 : {4'h0, wv[pb[i]]}, 1'b0);
            tick();
        end

        // bypass vs no bypass on r2
        we4 = 1'b1; selw4 = 2'd2; inw4 = 4'h1;
        tick();
        inw4 = 4'h9; sela4 = 2'd2; selb4 = 2'd2;
        push(0, "byp_same", 8'h09, 8'h09, 1'b0);
        push(1, "nobyp_same", 8'h01, 8'h01, 1'b0);
        push(3, "byp_same_z", 8'h09, 8'h09, 1'b0);
        tick();
        we4 = 1'b0;
        for (int d = 0; d < 4; d++) if (d != 2) push(d, "byp_next", 8'h09, 8'h09, 1'b0);
        tick();

        // zero r0: r0=A, r1=5 beforehand
        we4 = 1'b1; selw4 = 2'd0; inw4 = 4'hF; sela4 = 2'd0; selb4 = 2'd1;
        push(3, "z_wcyc", 8'h00, 8'h05, 1'b0);
        push(0, "r0_byp", 8'h0F, 8'h05, 1'b0);
        tick();
        we4 = 1'b0;
        push(3, "z_after", 8'h00, 8'h05, 1'b0);
        push(0, "r0_after", 8'h0F, 8'h05, 1'b0);
        tick();
        we4 = 1'b1; selw4 = 2'd1; inw4 = 4'hF; sela4 = 2'd1; selb4 = 2'd0;
        push(3, "z_r1_byp", 8'h0F, 8'h00, 1'b0);
        push(0, "r1_byp", 8'h0F, 8'h0F, 1'b0);
        tick();
        we4 = 1'b0; selb4 = 2'd1;
        push(3, "z_r1", 8'h0F, 8'h0F, 1'b0);
        tick();

        // CLR + WE together: write dropped, no bypass; then the clear sequence
        clr4 = 1'b1; we4 = 1'b1; selw4 = 2'd1; inw4 = 4'h7; sela4 = 2'd1; selb4 = 2'd3;
        for (int d = 0; d < 4; d++) if (d != 2) push(d, "clr_we", 8'h0F, 8'h03, 1'b0);
        tick();
        clr4 = 1'b0; we4 = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            for (int d = 0; d < 4; d++) if (d != 2)
                push(d, "clr4_seq", (c <= 2) ? 8'h0F : 8'h00,
                     (c <= 4) ? 8'h03 : 8'h00, (c <= 4) ? 1'b1 : 1'b0);
            tick();
        end

        // 8x8 clear: fill with FF, clear, writes during BUSY dropped
        for (int i = 0; i < 8; i++) begin
            we8 = 1'b1; selw8 = 3'(i); inw8 = 8'hFF;
            tick();
        end
        we8 = 1'b0; sela8 = 3'd5; selb8 = 3'd7; clr8 = 1'b1;
        push(2, "d8_full", 8'hFF, 8'hFF, 1'b0);
        tick();
        clr8 = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            we8 = 1'b1; selw8 = 3'd5; inw8 = 8'h42;
            push(2, "d8_seq", (c <= 6) ? 8'hFF : 8'h00, (c <= 8) ? 8'hFF : 8'h00, 1'b1);
            tick();
        end
        selw8 = 3'd7; inw8 = 8'h42;
        push(2, "d8_first_wr", 8'h00, 8'h42, 1'b0);
        tick();
        we8 = 1'b0;
        for (int k = 0; k < 7; k++) begin
            sela8 = 3'(k);
            push(2, "d8_zero", 8'h00, 8'h42, 1'b0);
            tick();
        end

        // reset in the middle of a DEPTH=4 clear
        we4 = 1'b1; selw4 = 2'd2; inw4 = 4'hA;
        tick();
        selw4 = 2'd3; inw4 = 4'hB;
        tick();
        we4 = 1'b0; clr4 = 1'b1;
        tick();
        clr4 = 1'b0;
        tick();
        tick();
        #1;
        rst = 1'b1; we4 = 1'b1; selw4 = 2'd3; inw4 = 4'h5; sela4 = 2'd2; selb4 = 2'd3;
        for (int d = 0; d < 4; d++) if (d != 2) push(d, "rst_mid", 8'h00, 8'h00, 1'b0);
        tick();
        rst = 1'b0; we4 = 1'b0;
        for (int d = 0; d < 4; d++) if (d != 2) push(d, "no_resume", 8'h00, 8'h00, 1'b0);
        tick();
        we4 = 1'b1; selw4 = 2'd3; inw4 = 4'h6;
        tick();
        we4 = 1'b0; sela4 = 2'd3; selb4 = 2'd3;
        for (int d = 0; d < 4; d++) if (d != 2) push(d, "r3_after_rst", 8'h06, 8'h06, 1'b0);
        tick();
        tick();

        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending, want 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_file_n.md
# reg_file_n

Parametrised successor to the 4x4-bit register file. It provides `DEPTH` registers of `WIDTH` bits, with two combinational read ports and one synchronous write port. Optional features are write-to-read bypass, a hardwired-zero register 0, and a sequenced bulk-clear engine with a busy flag. It sits between the instruction decoder, which drives the selects, and the ALU, which consumes `OUT_A`/`OUT_B` and produces `IN_W`.

## Interface
- `WIDTH`, default 4: data width of each register.
- `DEPTH`, default 4: number of registers. Must be a power of 2 and ≥ 2.
- `AW`, default `$clog2(DEPTH)`: select width. Derived; do not override.
- `BYPASS`, default 1: when 1, a same-cycle write is forwarded to matching read ports.
- `ZERO_R0`, default 0: when 1, register 0 always reads 0 and ignores writes.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `WE`  in  1  write enable.
- `SEL_W`  in  AW  write register index.
- `IN_W`  in  WIDTH  write data.
- `SEL_A`  in  AW  read port A index.
- `SEL_B`  in  AW  read port B index.
- `OUT_A`  out  WIDTH  read port A data (combinational).
- `OUT_B`  out  WIDTH  read port B data (combinational).
- `CLR`  in  1  bulk-clear request, sampled on the rising edge.
- `BUSY`  out  1  high while the clear sequence runs; registered.

## Operation
- Reset (asynchronous on `rst` high):
  - All registers are forced to 0.
  - FSM goes to IDLE, clear pointer to 0, `BUSY` to 0.
  - `OUT_A`/`OUT_B` therefore read 0 while `rst` is held.
- FSM states: IDLE, CLEAR.
- IDLE:
  - If `CLR`=1 at an edge: go to CLEAR, pointer to 0, `BUSY` to 1. Any `WE` in that same cycle is dropped (CLR has priority).
  - Otherwise, if `WE`=1: `reg[SEL_W]` takes `IN_W` at the edge.
- CLEAR:
  - Each edge writes 0 to `reg[ptr]` and increments `ptr`.
  - On the edge that clears `reg[DEPTH-1]`: go to IDLE, `BUSY` to 0, `ptr` to 0.
  - `WE` is ignored throughout CLEAR; dropped writes are not queued.
  - `CLR` is ignored throughout CLEAR.
- Reads are combinational:
  - `OUT_x = reg[SEL_x]`.
  - Reads during CLEAR return current contents, so they may be partially cleared.
- Bypass (`BYPASS`=1):
  - Applies when `WE`=1, the FSM is in IDLE, `CLR`=0, and `SEL_x == SEL_W`; then `OUT_x = IN_W` in that same cycle.
  - Both ports may bypass simultaneously.
  - No bypass when the write is being dropped.
- `ZERO_R0`=1:
  - Writes to index 0 are discarded.
  - `OUT_x` is 0 whenever `SEL_x`=0, and bypass is suppressed for index 0.
- `ZERO_R0`=0: register 0 behaves like any other register.
- Widths:
  - `ptr` is AW bits.
  - The terminal condition is `ptr == DEPTH-1`; no wrap-around is relied on.
  - No arithmetic on data.

## Timing
- Write latency: 1 edge. New value is visible on the read ports:
  - from the next cycle without bypass;
  - in the same cycle with bypass.
- Read latency: 0 cycles (combinational from `SEL_x` and the register array).
- Clear timing (edge E0 = edge sampling `CLR`=1 in IDLE):
  - `BUSY` rises after E0.
  - `reg[k]` is cleared at edge E(k+1).
  - `BUSY` falls after E(DEPTH). `BUSY` is high for exactly `DEPTH` cycles.
  - The first accepted write after a clear is sampled at E(DEPTH+1).
- Reset mid-clear: the sequence is abandoned immediately, all registers are 0, and `BUSY` is 0. No resume.
- `CLR` held high: a new clear starts at the first IDLE edge after the previous one ends. That is E(DEPTH+1), so `BUSY` drops for one cycle between sequences.

## Test plan
- Reset, then write 4'hA to r0, 4'h5 to r1, 4'hC to r2, 4'h3 to r3. Read (A,B) = (0,3), (1,2), (2,1), (3,0) → (A,3), (5,C), (C,5), (3,A).
- `BYPASS`=1: with r2=4'h1, set `WE`=1, `SEL_W`=2, `IN_W`=4'h9, `SEL_A`=`SEL_B`=2 → both outputs 9 in the write cycle. With `BYPASS`=0, both read 1 in that cycle and 9 the next.
- DEPTH=8, WIDTH=8, all registers 8'hFF. Pulse `CLR` → `BUSY` high for exactly 8 cycles. Reading r5 during the sequence gives FF through E5 and 00 from E6 on. Writes issued during `BUSY` leave all registers 0. After `BUSY` falls, a write of 8'h42 to r7 reads back 42.
- `CLR` and `WE` (r1 ← 4'h7) in the same IDLE cycle → write dropped, no bypass, r1 ends at 0.
- `ZERO_R0`=1: write 4'hF to r0 → `OUT_A` with `SEL_A`=0 reads 0, including in the write cycle. A write of 4'hF to r1 reads F.
- Assert `rst` asynchronously at cycle 3 of a DEPTH=4 clear, mid-clock → outputs 0 and `BUSY` 0 before the next edge. After release, r3 ← 4'h6 reads 6.
